// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with bus-mapped shadow registers, double-buffered
// period/on-time, polarity, one-shot mode and sticky status flags driving irq.
module pwm_multi_channel #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [7:0]        reg_addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  localparam int CW = CNT_WIDTH;
  localparam int MAP_END = BASE_ADDR + 4 * NUM_CH;

  typedef enum logic {IDLE, RUN} state_t;

  logic              in_map;
  logic [5:0]        off;
  logic [3:0]        ch_sel;
  logic [1:0]        reg_sel;
  logic [NUM_CH-1:0] irq_src;
  logic [31:0]       rb [NUM_CH][4];
  logic [31:0]       rd_word;
  logic              unused_wr;

  assign in_map  = ({24'd0, reg_addr} >= 32'(BASE_ADDR)) && ({24'd0, reg_addr} < 32'(MAP_END));
  assign off     = 6'(reg_addr - 8'(BASE_ADDR));
  assign ch_sel  = off[5:2];
  assign reg_sel = off[1:0];
  assign unused_wr = ^wr_data;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CW-1:0] per_sh, on_sh, per_act, on_act, cnt, cnt_inc;
    logic          en, pol, one, ien, pdone, odone, pwm;
    logic          sel, wr_per, wr_on, wr_cfg, rd_st, wrap, new_raw;
    state_t        state;

    assign sel     = in_map && (ch_sel == 4'(c));
    assign wr_per  = wr_en && sel && (reg_sel == 2'd0);
    assign wr_on   = wr_en && sel && (reg_sel == 2'd1);
    assign wr_cfg  = wr_en && sel && (reg_sel == 2'd2);
    assign rd_st   = rd_en && sel && (reg_sel == 2'd3);
    assign cnt_inc = cnt + CW'(1);
    assign wrap    = (cnt == per_act - CW'(1));
    // Level of the first cycle of a period about to be loaded from the shadows.
    assign new_raw = (per_sh != '0) && (on_sh != '0);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state   <= IDLE;
        per_sh  <= '0;
        on_sh   <= '0;
        per_act <= '0;
        on_act  <= '0;
        cnt     <= '0;
        en      <= 1'b0;
        pol     <= 1'b0;
        one     <= 1'b0;
        ien     <= 1'b0;
        pdone   <= 1'b0;
        odone   <= 1'b0;
        pwm     <= 1'b0;
      end else begin
        if (wr_per) per_sh <= wr_data[CW-1:0];
        if (wr_on)  on_sh  <= wr_data[CW-1:0];
        if (rd_st) begin
          pdone <= 1'b0;
          odone <= 1'b0;
        end
        case (state)
          IDLE: begin
            cnt <= '0;
            if (en) begin
              state   <= RUN;
              per_act <= per_sh;
              on_act  <= on_sh;
              pwm     <= new_raw ^ pol;
            end else begin
              pwm <= pol;
            end
          end
          RUN: begin
            if (!en) begin
              state <= IDLE;
              cnt   <= '0;
              pwm   <= pol;
            end else if (per_act == '0) begin
              cnt     <= '0;
              per_act <= per_sh;
              on_act  <= on_sh;
              pwm     <= new_raw ^ pol;
            end else if (wrap) begin
              cnt   <= '0;
              pdone <= 1'b1;
              if (one) begin
                state <= IDLE;
                en    <= 1'b0;
                odone <= 1'b1;
                pwm   <= pol;
              end else begin
                per_act <= per_sh;
                on_act  <= on_sh;
                pwm     <= new_raw ^ pol;
              end
            end else begin
              cnt <= cnt_inc;
              pwm <= (cnt_inc < on_act) ^ pol;
            end
          end
          default: state <= IDLE;
        endcase
        // Placed after the FSM so a bus write beats the one-shot hardware clear.
        if (wr_cfg) {ien, one, pol, en} <= wr_data[3:0];
      end
    end

    assign pwm_out[c] = pwm;
    assign irq_src[c] = ien && (pdone || odone);
    assign rb[c][0]   = 32'(per_sh);
    assign rb[c][1]   = 32'(on_sh);
    assign rb[c][2]   = {28'd0, ien, one, pol, en};
    assign rb[c][3]   = {29'd0, odone, pdone, state == RUN};
  end

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == 4'(c)) rd_word = rb[c][reg_sel];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq      <= |irq_src;
      rd_valid <= rd_en && in_map;
      rd_data  <= (rd_en && in_map) ? rd_word : 32'd0;
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: directed scenarios plus random bus traffic, all
// compared every cycle against a period/phase reference model.
module tb_pwm_multi_channel;

  localparam int NUM_CH = 4;
  localparam int CW     = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [7:0]        reg_addr = '0;
  logic [31:0]       wr_data = '0;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic [NUM_CH-1:0] pwm_out;
  logic              irq;

  always #5 clk = ~clk;

  pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .reg_addr(reg_addr),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .pwm_out(pwm_out),
    .irq(irq)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: each running channel is "phase cycles into a period of
  // length per with on cycles active"; the output follows directly from that.
  int unsigned       m_per_sh [NUM_CH];
  int unsigned       m_on_sh  [NUM_CH];
  int unsigned       m_per    [NUM_CH];
  int unsigned       m_on     [NUM_CH];
  int unsigned       m_phase  [NUM_CH];
  bit                m_en [NUM_CH], m_pol [NUM_CH], m_one [NUM_CH], m_ien [NUM_CH];
  bit                m_pd [NUM_CH], m_od [NUM_CH], m_run [NUM_CH];
  bit [NUM_CH-1:0]   m_pwm;
  bit                m_irq, m_rv;
  logic [31:0]       m_rd;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_per_sh[c] = 0; m_on_sh[c] = 0; m_per[c] = 0; m_on[c] = 0; m_phase[c] = 0;
      m_en[c] = 0; m_pol[c] = 0; m_one[c] = 0; m_ien[c] = 0;
      m_pd[c] = 0; m_od[c] = 0; m_run[c] = 0;
    end
    m_pwm = '0; m_irq = 0; m_rv = 0; m_rd = '0;
  endfunction

  function automatic void model_step(bit we, bit re, logic [7:0] a, logic [31:0] d);
    int ai, ch, r;
    bit hit, irq_next;
    ai = int'(a); ch = ai / 4; r = ai % 4; hit = (ai < 4 * NUM_CH);
    irq_next = 0;
    for (int c = 0; c < NUM_CH; c++) irq_next |= m_ien[c] && (m_pd[c] || m_od[c]);
    m_rv = re && hit;
    m_rd = '0;
    if (m_rv) begin
      case (r)
        0: m_rd = 32'(m_per_sh[ch]);
        1: m_rd = 32'(m_on_sh[ch]);
        2: m_rd = {28'd0, m_ien[ch], m_one[ch], m_pol[ch], m_en[ch]};
        default: m_rd = {29'd0, m_od[ch], m_pd[ch], m_run[ch]};
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (re && hit && ch == c && r == 3) begin m_pd[c] = 0; m_od[c] = 0; end
      if (!m_run[c]) begin
        if (m_en[c]) begin
          m_run[c] = 1; m_per[c] = m_per_sh[c]; m_on[c] = m_on_sh[c]; m_phase[c] = 0;
        end
      end else if (!m_en[c]) begin
        m_run[c] = 0; m_phase[c] = 0;
      end else if (m_per[c] == 0) begin
        m_per[c] = m_per_sh[c]; m_on[c] = m_on_sh[c]; m_phase[c] = 0;
      end else if (m_phase[c] == m_per[c] - 1) begin
        m_pd[c] = 1; m_phase[c] = 0;
        if (m_one[c]) begin
          m_run[c] = 0; m_en[c] = 0; m_od[c] = 1;
        end else begin
          m_per[c] = m_per_sh[c]; m_on[c] = m_on_sh[c];
        end
      end else begin
        m_phase[c]++;
      end
      m_pwm[c] = m_run[c] ? ((m_per[c] != 0 && m_phase[c] < m_on[c]) ^ m_pol[c]) : m_pol[c];
      if (we && hit && ch == c) begin
        case (r)
          0: m_per_sh[c] = int'(d[CW-1:0]);
          1: m_on_sh[c]  = int'(d[CW-1:0]);
          2: begin m_en[c] = d[0]; m_pol[c] = d[1]; m_one[c] = d[2]; m_ien[c] = d[3]; end
          default: ;
        endcase
      end
    end
    m_irq = irq_next;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input bit we, input bit re, input logic [7:0] a, input logic [31:0] d);
    wr_en = we; rd_en = re; reg_addr = a; wr_data = d;
    @(posedge clk);
    model_step(we, re, a, d);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", rd_data, m_rd);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #3 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int ones;
  logic [5:0] seq;

  initial begin
    model_reset();
    #12;
    do_reset();
    for (int a = 0; a < 4 * NUM_CH; a++) cycle(1'b0, 1'b1, 8'(a), 32'd0);
    cycle(1'b0, 1'b1, 8'h40, 32'd0);
    chk("unmapped_rd_valid", 32'(rd_valid), 32'd0);

    // ch0 10/3 continuous
    cycle(1'b1, 1'b0, 8'd0, 32'd10);
    cycle(1'b1, 1'b0, 8'd1, 32'd3);
    cycle(1'b1, 1'b0, 8'd2, 32'd1);
    idle(2);
    ones = 0;
    for (int i = 0; i < 10; i++) begin cycle(1'b0, 1'b0, 8'd0, 32'd0); ones += int'(pwm_out[0]); end
    chk("duty_10_3", 32'(ones), 32'd3);
    cycle(1'b0, 1'b1, 8'd3, 32'd0);
    chk("status_running", 32'(rd_data[0]), 32'd1);
    // mid-period on-time change takes effect at the next wrap
    cycle(1'b1, 1'b0, 8'd1, 32'd7);
    idle(25);
    ones = 0;
    for (int i = 0; i < 10; i++) begin cycle(1'b0, 1'b0, 8'd0, 32'd0); ones += int'(pwm_out[0]); end
    chk("duty_10_7", 32'(ones), 32'd7);

    // one-shot, active-low, 4/2
    do_reset();
    cycle(1'b1, 1'b0, 8'd0, 32'd4);
    cycle(1'b1, 1'b0, 8'd1, 32'd2);
    cycle(1'b1, 1'b0, 8'd2, 32'd7);
    for (int i = 0; i < 6; i++) begin cycle(1'b0, 1'b0, 8'd0, 32'd0); seq[i] = pwm_out[0]; end
    chk("oneshot_seq", 32'(seq), 32'h3c);
    cycle(1'b0, 1'b1, 8'd2, 32'd0);
    chk("oneshot_cfg", rd_data, 32'h6);
    cycle(1'b0, 1'b1, 8'd3, 32'd0);
    chk("oneshot_status", rd_data, 32'h6);
    cycle(1'b0, 1'b1, 8'd3, 32'd0);
    chk("oneshot_status_clr", rd_data, 32'h0);

    // duty boundaries: 0%, 100%, period 0
    do_reset();
    cycle(1'b1, 1'b0, 8'd0, 32'd10);
    cycle(1'b1, 1'b0, 8'd1, 32'd0);
    cycle(1'b1, 1'b0, 8'd2, 32'd1);
    idle(20);
    chk("duty_zero", 32'(pwm_out[0]), 32'd0);
    cycle(1'b1, 1'b0, 8'd1, 32'd12);
    idle(22);
    chk("duty_full", 32'(pwm_out[0]), 32'd1);
    cycle(1'b1, 1'b0, 8'd0, 32'd0);
    idle(15);
    chk("period_zero", 32'(pwm_out[0]), 32'd0);

    // irq from ch2 only
    do_reset();
    cycle(1'b1, 1'b0, 8'd4, 32'd5);
    cycle(1'b1, 1'b0, 8'd5, 32'd2);
    cycle(1'b1, 1'b0, 8'd6, 32'd1);
    cycle(1'b1, 1'b0, 8'd8, 32'd7);
    cycle(1'b1, 1'b0, 8'd9, 32'd3);
    cycle(1'b1, 1'b0, 8'd10, 32'd9);
    idle(12);
    chk("irq_ch2", 32'(irq), 32'd1);
    cycle(1'b0, 1'b1, 8'd11, 32'd0);
    idle(3);
    cycle(1'b0, 1'b1, 8'd7, 32'd0);
    idle(10);

    // random bus traffic
    for (int i = 0; i < 600; i++) begin
      int op, ch, r;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, NUM_CH - 1);
      r  = $urandom_range(0, 3);
      if (op < 4) begin
        idle(1);
      end else if (op < 7) begin
        case (r)
          0: d = 32'($urandom_range(0, 12));
          1: d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 14));
          2: d = ($urandom & 32'hffff_fff0) | 32'($urandom_range(0, 15));
          default: d = 32'($urandom);
        endcase
        cycle(1'b1, 1'b0, 8'(4 * ch + r), d);
      end else begin
        cycle(1'b0, 1'b1, 8'($urandom_range(0, 4 * NUM_CH + 3)), 32'd0);
      end
    end

    // reset in the middle of running periods, with an active-low channel
    for (int c = 0; c < NUM_CH; c++) begin
      cycle(1'b1, 1'b0, 8'(4 * c), 32'd9);
      cycle(1'b1, 1'b0, 8'(4 * c + 1), 32'd4);
      cycle(1'b1, 1'b0, 8'(4 * c + 2), (c == 1) ? 32'hb : 32'h9);
    end
    idle(5);
    do_reset();
    for (int a = 0; a < 4 * NUM_CH; a++) begin
      cycle(1'b0, 1'b1, 8'(a), 32'd0);
      chk("post_reset_reg", rd_data, 32'd0);
    end
    cycle(1'b0, 1'b1, 8'hff, 32'd0);
    chk("unmapped_ff", 32'(rd_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
